// File: rtl/fifo_flowctl.sv
// Per-port data FIFO with programmable pause/continue flow-control pulses,
// a sticky overflow flag, and empty/full status for the switch control FSM.
module fifo_flowctl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic [ADDR_W:0]   thr_high_in,
  input  logic [ADDR_W:0]   thr_low_in,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              pause,
  output logic              cont,
  output logic              error_full
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] THR_HIGH_R = (ADDR_W+1)'(DEPTH - 2);
  localparam logic [ADDR_W:0] THR_LOW_R  = (ADDR_W+1)'(2);

  typedef enum logic {RUNNING, PAUSED} fc_state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   thr_high, thr_low;
  logic [ADDR_W:0]   count_next;
  logic              pop_ok, push_ok;
  fc_state_t         fc_state, fc_state_next;
  logic              pause_next, cont_next;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

  always_comb begin
    pop_ok     = pop & (count != '0);
    push_ok    = push & ((count != DEPTH_C) | pop_ok);
    count_next = count + (ADDR_W+1)'(push_ok) - (ADDR_W+1)'(pop_ok);
  end

  // Pause takes priority over continue, which keeps misprogrammed
  // thresholds (thr_high <= thr_low) deterministic.
  always_comb begin
    fc_state_next = fc_state;
    pause_next    = 1'b0;
    cont_next     = 1'b0;
    if (fc_state == RUNNING && count_next >= thr_high) begin
      fc_state_next = PAUSED;
      pause_next    = 1'b1;
    end else if (fc_state == PAUSED && count_next <= thr_low) begin
      fc_state_next = RUNNING;
      cont_next     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !rst) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      pause      <= 1'b0;
      cont       <= 1'b0;
      error_full <= 1'b0;
      fc_state   <= RUNNING;
      thr_high   <= THR_HIGH_R;
      thr_low    <= THR_LOW_R;
    end else begin
      if (init) begin
        thr_high <= thr_high_in;
        thr_low  <= thr_low_in;
      end
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= mem[rd_ptr];
      end
      valid_out <= pop_ok;
      count     <= count_next;
      if (push && full && !pop_ok) error_full <= 1'b1;
      fc_state  <= fc_state_next;
      pause     <= pause_next;
      cont      <= cont_next;
    end
  end

endmodule

// File: tb/tb_fifo_flowctl.sv
// Randomized scoreboard bench for fifo_flowctl against a queue-based reference model.
module tb_fifo_flowctl;

  logic       clk = 1'b0;
  logic       rst, init, push, pop;
  logic [3:0] thr_high_in, thr_low_in;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       valid_out, empty, full, pause, cont, error_full;
  logic [3:0] count;

  fifo_flowctl #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .init(init),
    .thr_high_in(thr_high_in), .thr_low_in(thr_low_in),
    .push(push), .data_in(data_in), .pop(pop),
    .data_out(data_out), .valid_out(valid_out),
    .empty(empty), .full(full), .count(count),
    .pause(pause), .cont(cont), .error_full(error_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cnt;
    bit          pause;
    bit          cont;
    bit          valid;
    bit          err;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] data_q[$];
  int         checks = 0;
  int         errors = 0;

  // reference model state
  logic [7:0]  fifo_m[$];
  bit          paused_m = 0;
  bit          err_m = 0;
  int unsigned thh_m = 6, thl_m = 2;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input bit r, input bit ps, input bit pp, input logic [7:0] d,
                      input bit in, input int unsigned th, input int unsigned tl);
    exp_t e;
    bit pop_ok, push_ok;
    int unsigned n;
    rst = r; push = ps; pop = pp; data_in = d; init = in;
    thr_high_in = 4'(th); thr_low_in = 4'(tl);
    e = '{cnt: 0, pause: 0, cont: 0, valid: 0, err: 0};
    if (r) begin
      fifo_m.delete();
      paused_m = 0; err_m = 0; thh_m = 6; thl_m = 2;
    end else begin
      pop_ok  = pp && fifo_m.size() > 0;
      push_ok = ps && (fifo_m.size() < 8 || pop_ok);
      if (ps && fifo_m.size() == 8 && !pop_ok) err_m = 1;
      if (pop_ok) data_q.push_back(fifo_m.pop_front());
      if (push_ok) fifo_m.push_back(d);
      n = fifo_m.size();
      if (!paused_m && n >= thh_m) begin
        paused_m = 1; e.pause = 1;
      end else if (paused_m && n <= thl_m) begin
        paused_m = 0; e.cont = 1;
      end
      if (in) begin thh_m = th; thl_m = tl; end
      e.valid = pop_ok;
      e.cnt   = n;
      e.err   = err_m;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // monitor: one expectation per clock, read data checked whenever valid_out is seen
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("count", int'(count), int'(e.cnt));
        check("empty", int'(empty), int'(e.cnt == 0));
        check("full", int'(full), int'(e.cnt == 8));
        check("pause", int'(pause), int'(e.pause));
        check("cont", int'(cont), int'(e.cont));
        check("valid_out", int'(valid_out), int'(e.valid));
        check("error_full", int'(error_full), int'(e.err));
      end
      if (valid_out === 1'b1) begin
        if (data_q.size() == 0) check("unexpected_valid", 1, 0);
        else check("data_out", int'(data_out), int'(data_q.pop_front()));
      end
    end
  end

  initial begin
    bit r, ps, pp, in;
    step(1, 0, 0, 8'h00, 0, 0, 0);
    step(1, 0, 0, 8'h00, 0, 0, 0);
    repeat (3) step(0, 0, 0, 8'h00, 0, 0, 0);
    // in-order fill and drain with default thresholds
    for (int i = 0; i < 8; i++) step(0, 1, 0, 8'(8'h11 + i), 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 8'h00, 0, 0, 0);
    // hysteresis with thresholds 6/2
    step(0, 0, 0, 8'h00, 1, 6, 2);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 8'(8'h30 + i), 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 8'h00, 0, 0, 0);
    // overflow then simultaneous push+pop on full, then reset
    for (int i = 0; i < 8; i++) step(0, 1, 0, 8'(8'h40 + i), 0, 0, 0);
    step(0, 1, 0, 8'hEE, 0, 0, 0);
    step(0, 1, 1, 8'h50, 0, 0, 0);
    step(1, 0, 0, 8'h00, 0, 0, 0);
    // push+pop on empty: no bypass
    step(0, 1, 1, 8'hA5, 0, 0, 0);
    step(0, 0, 1, 8'h00, 0, 0, 0);
    // reset mid-stream
    step(0, 0, 0, 8'h00, 1, 3, 1);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'(8'h60 + i), 0, 0, 0);
    step(1, 1, 0, 8'h70, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 8'(8'h71 + i), 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 8'h00, 0, 0, 0);
    // randomized traffic, including misprogrammed thresholds
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      in = ($urandom_range(0, 39) == 0);
      ps = ($urandom_range(0, 99) < 55);
      pp = ($urandom_range(0, 99) < 50);
      step(r, ps, pp, 8'($urandom), in, $urandom_range(0, 9), $urandom_range(0, 9));
    end
    step(0, 0, 0, 8'h00, 0, 0, 0);
    repeat (2) @(posedge clk);
    #3;
    check("pending_expectations", exp_q.size() + data_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
